led_cube_anim_scheduler: RTL and testbench
==========================================

Name: led_cube_anim_scheduler

Overview:
- Sequences the LED cube frame driver. It decides which animation and which frame the datapath shows, and when each frame starts.
- Sits between the user/config logic (start, stop, pause, loop select) and the single-frame driver (start/done handshake).
- Outputs anim_sel and frame_idx. The animation ROM mux uses these to form the data address.
- Replaces the free-running frame timer, offset counter and loop counter with one handshaked scheduler.

Parameters:
- NUM_ANIM, 7: number of stored animations.
- FRAMES_PER_ANIM, 150: frames per animation.
- FRAME_TICKS, 1500000: minimum clk cycles a frame is displayed.
- LOOPS, 5: plays of one animation before advancing (loop_mode only).
- ANIM_W, 3: anim_sel width; 2**ANIM_W >= NUM_ANIM.
- FRAME_W, 8: frame_idx width.
- TICK_W, 21: frame timer width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- play_start  in  1  begin playback (level or pulse; acted on only in IDLE)
- play_stop  in  1  abort playback
- pause  in  1  freeze frame timer while high
- loop_mode  in  1  1 = auto-cycle animations, 0 = play manual_sel
- manual_sel  in  ANIM_W  animation to play when loop_mode=0
- frame_done  in  1  single-cycle pulse from frame driver
- frame_start  out  1  one-cycle pulse to frame driver
- frame_stop  out  1  one-cycle abort to frame driver
- anim_sel  out  ANIM_W  current animation
- frame_idx  out  FRAME_W  current frame within animation
- loop_cnt  out  3  completed plays of current animation
- anim_wrap  out  1  one-cycle pulse when anim_sel advances
- busy  out  1  state != IDLE

Behaviour:
- Reset is rst_n synchronous, active-low, on clk. All outputs and registers go to 0; state goes to IDLE.
- States: IDLE, KICK, RUN, PAUSED, ADVANCE.
- IDLE, on play_start:
  - anim_sel <= loop_mode ? 0 : manual_sel.
  - frame_idx <= 0; loop_cnt <= 0.
  - Go to KICK.
- KICK (exactly 1 cycle):
  - frame_start = 1.
  - timer <= 0; done_seen <= 0.
  - Go to RUN.
  - frame_done is ignored in KICK.
- RUN:
  - timer increments each cycle.
  - done_seen is set on frame_done.
  - Expiry is timer == FRAME_TICKS-1.
  - On expiry with (done_seen | frame_done): go to ADVANCE.
  - On expiry without done: timer holds at FRAME_TICKS-1 and the block waits for frame_done.
  - If pause is high (and no stop): go to PAUSED.
- PAUSED:
  - Timer frozen; frame_done is still captured into done_seen.
  - Go back to RUN when pause falls.
- ADVANCE (1 cycle), then KICK:
  - If frame_idx == FRAMES_PER_ANIM-1: frame_idx wraps to 0. Otherwise frame_idx increments.
  - On wrap with loop_mode=1:
    - If loop_cnt == LOOPS-1: loop_cnt <= 0; anim_sel <= (anim_sel == NUM_ANIM-1) ? 0 : anim_sel+1; anim_wrap = 1.
    - Otherwise loop_cnt increments.
  - On wrap with loop_mode=0: anim_sel <= manual_sel; loop_cnt <= 0.
  - manual_sel changes take effect only at a wrap.
- Nominal frame period (frame_done arrives before expiry) = FRAME_TICKS + 2 cycles, measured frame_start to frame_start.
- frame_start is asserted in the cycle after play_start is sampled.
- Priority is rst_n > play_stop > pause > normal transitions.
- play_stop in any non-IDLE state:
  - frame_stop = 1 for that cycle (combinational: play_stop & busy).
  - Next state is IDLE.
  - anim_sel, frame_idx and loop_cnt hold their values.
  - play_stop in IDLE produces no frame_stop.
- play_start outside IDLE is ignored.
- A play_start and play_stop asserted together in IDLE: stop wins and the block stays in IDLE.
- loop_mode falling mid-animation: loop_cnt is cleared at the next wrap.
- frame_done while in IDLE or KICK is dropped.
- All arithmetic is unsigned, with explicit wrap compares. The timer never exceeds FRAME_TICKS-1.

Decomposition:
- Shared package led_cube_pkg holds:
  - Typedef sched_state_e {IDLE, KICK, RUN, PAUSED, ADVANCE}.
  - Default constants for frame time, frames per animation, loops and animation count, replacing the current `defines.
- One sub-module, led_cube_frame_timer:
  - Inputs clr, en. Output expired.
  - Saturating at FRAME_TICKS-1.
  - Parameters FRAME_TICKS and TICK_W.

Test Plan:
- Bench parameters for all scenarios: FRAME_TICKS=4, FRAMES_PER_ANIM=3, LOOPS=2, NUM_ANIM=3.
- Release reset, play_start, loop_mode=0, manual_sel=1, frame_done 2 cycles after each frame_start -> first frame_start 1 cycle after play_start, then one every 6 cycles; frame_idx 0,1,2,0; anim_sel=1; busy=1.
- frame_done returned 10 cycles after frame_start -> ADVANCE waits for it; frame_start-to-frame_start period = 12; frame_idx advances once.
- loop_mode=1, prompt done -> after 6 frames anim_sel 0->1 with a single anim_wrap pulse; loop_cnt sequence 0,1,0; after 18 frames anim_sel back to 0.
- pause held 5 cycles in mid-RUN -> period becomes 11; frame_idx unchanged during pause; a frame_done received while paused still allows advance.
- play_stop asserted together with pause in RUN -> frame_stop high exactly 1 cycle; IDLE next cycle; busy=0; frame_idx held; a following play_start restarts at frame_idx=0, loop_cnt=0.
- loop_mode=0, manual_sel changed 0->2 at frame_idx=1 -> anim_sel stays 0 until the frame_idx 2->0 wrap, then becomes 2.
- rst_n low mid-RUN -> next cycle: all outputs 0, state IDLE, no frame_start.

Source files
------------

// File: rtl/led_cube_anim_scheduler_pkg.sv
// led_cube_pkg: shared scheduler state type and default animation timing constants.
// No ports; imported by the scheduler top and its frame timer.
package led_cube_pkg;
    typedef enum logic [2:0] {IDLE, KICK, RUN, PAUSED, ADVANCE} sched_state_e;
    localparam int DEF_FRAME_TICKS     = 1500000;
    localparam int DEF_FRAMES_PER_ANIM = 150;
    localparam int DEF_LOOPS           = 5;
    localparam int DEF_NUM_ANIM        = 7;
endpackage

// File: rtl/led_cube_anim_scheduler_frame_timer.sv
// led_cube_frame_timer: minimum frame display timer, saturating at FRAME_TICKS-1.
// Ports: clk, rst_n (sync active-low), clr (restart at 0), en (count), expired (timer at FRAME_TICKS-1).
module led_cube_frame_timer
    import led_cube_pkg::*;
#(
    parameter int FRAME_TICKS = DEF_FRAME_TICKS,
    parameter int TICK_W      = 21
)(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(FRAME_TICKS - 1);
    logic [TICK_W-1:0] timer;
    assign expired = timer == LAST_TICK;
    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            timer <= '0;
        else if (en && !expired)
            timer <= timer + 1'b1;
    end
endmodule

// File: rtl/led_cube_anim_scheduler.sv
// led_cube_anim_scheduler: handshaked animation/frame sequencer for the LED cube frame driver.
// Ports: clk, rst_n (sync active-low); play_start/play_stop/pause/loop_mode/manual_sel from config;
// frame_done from the frame driver; frame_start/frame_stop to the frame driver;
// anim_sel/frame_idx address the animation ROM; loop_cnt, anim_wrap, busy report progress.
module led_cube_anim_scheduler
    import led_cube_pkg::*;
#(
    parameter int NUM_ANIM        = DEF_NUM_ANIM,
    parameter int FRAMES_PER_ANIM = DEF_FRAMES_PER_ANIM,
    parameter int FRAME_TICKS     = DEF_FRAME_TICKS,
    parameter int LOOPS           = DEF_LOOPS,
    parameter int ANIM_W          = 3,
    parameter int FRAME_W         = 8,
    parameter int TICK_W          = 21
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               play_start,
    input  logic               play_stop,
    input  logic               pause,
    input  logic               loop_mode,
    input  logic [ANIM_W-1:0]  manual_sel,
    input  logic               frame_done,
    output logic               frame_start,
    output logic               frame_stop,
    output logic [ANIM_W-1:0]  anim_sel,
    output logic [FRAME_W-1:0] frame_idx,
    output logic [2:0]         loop_cnt,
    output logic               anim_wrap,
    output logic               busy
);
    localparam logic [ANIM_W-1:0]  LAST_ANIM  = ANIM_W'(NUM_ANIM - 1);
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAMES_PER_ANIM - 1);
    localparam logic [2:0]         LAST_LOOP  = 3'(LOOPS - 1);
    sched_state_e state, state_nxt;
    logic done_seen, expired, frame_wrap, loop_wrap;
    led_cube_frame_timer #(.FRAME_TICKS(FRAME_TICKS), .TICK_W(TICK_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state == KICK),
        .en      (state == RUN),
        .expired (expired)
    );
    assign busy       = state != IDLE;
    assign frame_stop = play_stop && busy;
    assign frame_wrap = frame_idx == LAST_FRAME;
    assign loop_wrap  = loop_mode && loop_cnt == LAST_LOOP;
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    // play_stop overrides every non-IDLE transition, so pulses from KICK/ADVANCE are suppressed too
    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        anim_wrap   = 1'b0;
        if (frame_stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = (play_start && !play_stop) ? KICK : IDLE;
                KICK:    begin
                    frame_start = 1'b1;
                    state_nxt   = RUN;
                end
                RUN:     state_nxt = pause ? PAUSED : (expired && (done_seen || frame_done)) ? ADVANCE : RUN;
                PAUSED:  state_nxt = pause ? PAUSED : RUN;
                ADVANCE: begin
                    anim_wrap = frame_wrap && loop_wrap;
                    state_nxt = KICK;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            anim_sel  <= '0;
            frame_idx <= '0;
            loop_cnt  <= '0;
            done_seen <= 1'b0;
        end else begin
            if (state == IDLE && state_nxt == KICK) begin
                anim_sel  <= loop_mode ? '0 : manual_sel;
                frame_idx <= '0;
                loop_cnt  <= '0;
            end
            if (state == KICK)
                done_seen <= 1'b0;
            else if ((state == RUN || state == PAUSED) && frame_done)
                done_seen <= 1'b1;
            if (state == ADVANCE && state_nxt == KICK) begin
                frame_idx <= frame_wrap ? '0 : frame_idx + 1'b1;
                if (frame_wrap) begin
                    if (!loop_mode) begin
                        anim_sel <= manual_sel;
                        loop_cnt <= '0;
                    end else if (loop_wrap) begin
                        loop_cnt <= '0;
                        anim_sel <= (anim_sel == LAST_ANIM) ? '0 : anim_sel + 1'b1;
                    end else begin
                        loop_cnt <= loop_cnt + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_led_cube_anim_scheduler.sv
// tb_led_cube_anim_scheduler: directed self-checking bench for led_cube_anim_scheduler.
// Drives config and frame-driver handshake; checks timing, indices, loops, pause, stop, reset.
module tb_led_cube_anim_scheduler;
    localparam int FT = 4, FPA = 3, LP = 2, NA = 3, AW = 3, FW = 8, TW = 21;
    logic clk = 0, rst_n = 0, play_start = 0, play_stop = 0, pause = 0, loop_mode = 0, frame_done = 0;
    logic [AW-1:0] manual_sel = '0;
    logic frame_start, frame_stop, anim_wrap, busy;
    logic [AW-1:0] anim_sel;
    logic [FW-1:0] frame_idx;
    logic [2:0] loop_cnt;
    int total = 0, bad = 0, wraps = 0, per;
    logic mv;

    always #5 clk = ~clk;

    led_cube_anim_scheduler #(
        .NUM_ANIM(NA), .FRAMES_PER_ANIM(FPA), .FRAME_TICKS(FT), .LOOPS(LP),
        .ANIM_W(AW), .FRAME_W(FW), .TICK_W(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .play_start(play_start), .play_stop(play_stop),
        .pause(pause), .loop_mode(loop_mode), .manual_sel(manual_sel), .frame_done(frame_done),
        .frame_start(frame_start), .frame_stop(frame_stop), .anim_sel(anim_sel),
        .frame_idx(frame_idx), .loop_cnt(loop_cnt), .anim_wrap(anim_wrap), .busy(busy)
    );

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called in a frame_start cycle; returns cycles to the next frame_start.
    task automatic play_frame(input int dly, input int pst, input int plen, output int period, output logic moved);
        logic [FW-1:0] idx0;
        idx0 = frame_idx;
        moved = 0;
        period = 0;
        for (int k = 1; k <= 100; k++) begin
            cycle();
            frame_done = (k == dly);
            pause = (k >= pst) && (k < pst + plen);
            if (anim_wrap) wraps++;
            if (frame_start) begin
                period = k;
                break;
            end
            if (frame_idx !== idx0) moved = 1;
        end
        frame_done = 0;
        pause = 0;
        chk("frame_start_seen", frame_start, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) cycle();
        chk("rst_busy", busy, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_frame_idx", frame_idx, 0);
        chk("rst_anim_sel", anim_sel, 0);
        chk("rst_loop_cnt", loop_cnt, 0);
        chk("rst_anim_wrap", anim_wrap, 0);
        chk("rst_frame_stop", frame_stop, 0);

        rst_n = 1; loop_mode = 0; manual_sel = 1; play_start = 1;
        cycle();
        play_start = 0;
        chk("start_pulse", frame_start, 1);
        chk("start_busy", busy, 1);
        chk("start_anim", anim_sel, 1);
        chk("start_idx", frame_idx, 0);
        play_frame(2, 0, 0, per, mv);
        chk("period_f1", per, 6);
        chk("idx_f1", frame_idx, 1);
        play_frame(2, 0, 0, per, mv);
        chk("period_f2", per, 6);
        chk("idx_f2", frame_idx, 2);
        play_frame(2, 0, 0, per, mv);
        chk("period_f3", per, 6);
        chk("idx_f3", frame_idx, 0);
        chk("anim_f3", anim_sel, 1);
        chk("loop_f3", loop_cnt, 0);

        play_frame(10, 0, 0, per, mv);
        chk("period_late_done", per, 12);
        chk("idx_late_done", frame_idx, 1);

        play_frame(4, 2, 5, per, mv);
        chk("period_pause", per, 11);
        chk("idx_pause", frame_idx, 2);
        chk("idx_stable_pause", mv, 0);

        play_frame(2, 0, 0, per, mv);
        chk("idx_f6", frame_idx, 0);
        play_frame(2, 0, 0, per, mv);
        chk("idx_f7", frame_idx, 1);

        cycle(); cycle();
        play_stop = 1; pause = 1;
        #1;
        chk("stop_pulse", frame_stop, 1);
        cycle();
        play_stop = 0; pause = 0;
        #1;
        chk("stop_one_cycle", frame_stop, 0);
        chk("stop_busy", busy, 0);
        chk("stop_idx_held", frame_idx, 1);
        chk("stop_anim_held", anim_sel, 1);
        cycle();
        chk("stop_stays_idle", busy, 0);
        play_start = 1; play_stop = 1;
        #1;
        chk("idle_stop_no_pulse", frame_stop, 0);
        cycle();
        chk("start_stop_idle", busy, 0);
        play_stop = 0; loop_mode = 1;
        cycle();
        play_start = 0;
        chk("restart_pulse", frame_start, 1);
        chk("restart_idx", frame_idx, 0);
        chk("restart_loop", loop_cnt, 0);
        chk("restart_anim", anim_sel, 0);

        wraps = 0;
        for (int n = 1; n <= 21; n++) begin
            play_frame(2, 0, 0, per, mv);
            if (n == 2) chk("loop_n2", loop_cnt, 0);
            if (n == 3) chk("loop_n3", loop_cnt, 1);
            if (n == 5) chk("wraps_n5", wraps, 0);
            if (n == 6) begin
                chk("anim_n6", anim_sel, 1);
                chk("loop_n6", loop_cnt, 0);
                chk("wraps_n6", wraps, 1);
            end
            if (n == 12) chk("anim_n12", anim_sel, 2);
            if (n == 18) begin
                chk("anim_n18", anim_sel, 0);
                chk("wraps_n18", wraps, 3);
            end
        end
        chk("loop_n21", loop_cnt, 1);
        chk("idx_n21", frame_idx, 0);

        loop_mode = 0; manual_sel = 0;
        play_frame(2, 0, 0, per, mv);
        chk("man_idx1", frame_idx, 1);
        chk("man_loop_kept", loop_cnt, 1);
        manual_sel = 2;
        play_frame(2, 0, 0, per, mv);
        chk("man_idx2", frame_idx, 2);
        chk("man_anim_hold", anim_sel, 0);
        play_frame(2, 0, 0, per, mv);
        chk("man_idx_wrap", frame_idx, 0);
        chk("man_anim_new", anim_sel, 2);
        chk("man_loop_clr", loop_cnt, 0);

        cycle(); cycle();
        rst_n = 0;
        cycle();
        chk("mrst_busy", busy, 0);
        chk("mrst_frame_start", frame_start, 0);
        chk("mrst_anim", anim_sel, 0);
        chk("mrst_idx", frame_idx, 0);
        chk("mrst_loop", loop_cnt, 0);
        chk("mrst_wrap", anim_wrap, 0);
        chk("mrst_stop", frame_stop, 0);
        rst_n = 1;
        cycle();
        chk("mrst_no_start", frame_start, 0);
        chk("mrst_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
